// File: rtl/i2c_ext_pkg.sv
// Shared state encoding and default sizing for the I2C channel mux.
package i2c_ext_pkg;

   localparam int I2C_NUM_CH_DEF      = 8;
   localparam int I2C_SYNC_STAGES_DEF = 2;
   localparam int I2C_IDLE_CYCLES_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_SWITCH
   } i2c_state_e;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronises upstream SCL/SDA, flags START/STOP and counts idle-high cycles.
// scl_s_o/sda_s_o lag the pins by SYNC_STAGES cycles; no backpressure.
module i2c_bus_monitor
   import i2c_ext_pkg::*;
#(
   parameter int SYNC_STAGES = I2C_SYNC_STAGES_DEF,
   parameter int IDLE_CYCLES = I2C_IDLE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_s_o,
   output logic sda_s_o,
   output logic start_o,
   output logic stop_o,
   output logic bus_free_o
);

   localparam int CNT_W = $clog2(IDLE_CYCLES + 1);

   logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
   logic                   scl_prev_q, sda_prev_q;
   logic [CNT_W-1:0]       free_cnt_q;

   assign scl_s_o    = scl_sync_q[SYNC_STAGES-1];
   assign sda_s_o    = sda_sync_q[SYNC_STAGES-1];
   assign start_o    = scl_prev_q & scl_s_o & sda_prev_q & ~sda_s_o;
   assign stop_o     = scl_prev_q & scl_s_o & ~sda_prev_q & sda_s_o;
   assign bus_free_o = (free_cnt_q == CNT_W'(IDLE_CYCLES));

   // Presetting to 1 makes the bus look released straight out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
         free_cnt_q <= '0;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
         scl_prev_q <= scl_s_o;
         sda_prev_q <= sda_s_o;
         if (!(scl_s_o && sda_s_o) || start_o) begin
            free_cnt_q <= '0;
         end else if (!bus_free_o) begin
            free_cnt_q <= free_cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2c_channel_mux.sv
// Routes one upstream I2C port to one of NUM_CH channels; pin-to-pin latency SYNC_STAGES+1.
// Channel changes use a sel valid/ready handshake and are applied only after the bus has idled.
module i2c_channel_mux
   import i2c_ext_pkg::*;
#(
   parameter int NUM_CH      = I2C_NUM_CH_DEF,
   parameter int SEL_W       = $clog2(NUM_CH),
   parameter int SYNC_STAGES = I2C_SYNC_STAGES_DEF,
   parameter int IDLE_CYCLES = I2C_IDLE_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              scl_in,
   input  logic              sda_in,
   input  logic [SEL_W-1:0]  sel,
   input  logic              sel_valid,
   output logic              sel_ready,
   output logic              sel_done,
   output logic              sel_err,
   output logic [SEL_W-1:0]  active_ch,
   output logic              bus_busy,
   output logic [NUM_CH-1:0] scl_out,
   output logic [NUM_CH-1:0] sda_out
);

   logic scl_s, sda_s, start_p, stop_p, bus_free;

   i2c_bus_monitor #(
      .SYNC_STAGES (SYNC_STAGES),
      .IDLE_CYCLES (IDLE_CYCLES)
   ) u_mon (
      .clk        (clk),
      .rst        (rst),
      .scl_i      (scl_in),
      .sda_i      (sda_in),
      .scl_s_o    (scl_s),
      .sda_s_o    (sda_s),
      .start_o    (start_p),
      .stop_o     (stop_p),
      .bus_free_o (bus_free)
   );

   i2c_state_e        state_q;
   logic [SEL_W-1:0]  active_ch_q, pend_sel_q;
   logic              pend_q, sel_done_q, sel_err_q;
   logic [NUM_CH-1:0] scl_out_q, sda_out_q, scl_out_d, sda_out_d;
   logic              go_switch, accept, sel_bad;
   logic [SEL_W-1:0]  route_ch;

   assign sel_ready = !pend_q && (state_q != ST_SWITCH);
   assign accept    = sel_valid && sel_ready;
   assign sel_bad   = (32'(sel) >= NUM_CH);
   assign go_switch = (state_q == ST_IDLE) && pend_q && bus_free && !start_p;
   // During the SWITCH cycle the next routing already targets the new channel.
   assign route_ch  = (state_q == ST_SWITCH) ? pend_sel_q : active_ch_q;

   always_comb begin
      scl_out_d = '1;
      sda_out_d = '1;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!go_switch && (32'(route_ch) == i)) begin
            scl_out_d[i] = scl_s;
            sda_out_d[i] = sda_s;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         active_ch_q <= '0;
         pend_sel_q  <= '0;
         pend_q      <= 1'b0;
         sel_done_q  <= 1'b0;
         sel_err_q   <= 1'b0;
         scl_out_q   <= '1;
         sda_out_q   <= '1;
      end else begin
         scl_out_q  <= scl_out_d;
         sda_out_q  <= sda_out_d;
         sel_done_q <= 1'b0;
         sel_err_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_p) begin
                  state_q <= ST_BUSY;
               end else if (go_switch) begin
                  state_q <= ST_SWITCH;
               end
            end
            ST_BUSY: begin
               if (stop_p) begin
                  state_q <= ST_IDLE;
               end
            end
            ST_SWITCH: begin
               state_q     <= ST_IDLE;
               active_ch_q <= pend_sel_q;
               pend_q      <= 1'b0;
               sel_done_q  <= 1'b1;
            end
            default: state_q <= ST_IDLE;
         endcase
         // sel_ready is low in SWITCH, so this never collides with the apply above.
         if (accept) begin
            if (sel_bad) begin
               sel_err_q  <= 1'b1;
               sel_done_q <= 1'b1;
            end else if (sel == active_ch_q) begin
               sel_done_q <= 1'b1;
            end else begin
               pend_q     <= 1'b1;
               pend_sel_q <= sel;
            end
         end
      end
   end

   assign sel_done  = sel_done_q;
   assign sel_err   = sel_err_q;
   assign active_ch = active_ch_q;
   assign bus_busy  = (state_q == ST_BUSY);
   assign scl_out   = scl_out_q;
   assign sda_out   = sda_out_q;

endmodule

// File: tb/tb_i2c_channel_mux.sv
// Bench for i2c_channel_mux: two configurations share the upstream bus and are
// compared every cycle against a rule-level reference model, plus directed spot checks.
module tb_i2c_channel_mux;

   localparam int NCH0 = 8, SS0 = 2, IC0 = 16;
   localparam int NCH1 = 6, SS1 = 3, IC1 = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic scl_in = 1'b1, sda_in = 1'b1;
   logic [2:0] sel0 = '0, sel1 = '0;
   logic sel_valid0 = 1'b0, sel_valid1 = 1'b0;

   logic       sel_ready0, sel_done0, sel_err0, bus_busy0;
   logic [2:0] active_ch0;
   logic [7:0] scl_out0, sda_out0;
   logic       sel_ready1, sel_done1, sel_err1, bus_busy1;
   logic [2:0] active_ch1;
   logic [5:0] scl_out1, sda_out1;

   always #5 clk = ~clk;

   i2c_channel_mux #(.NUM_CH(NCH0), .SEL_W(3), .SYNC_STAGES(SS0), .IDLE_CYCLES(IC0)) dut0 (
      .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in), .sel(sel0), .sel_valid(sel_valid0),
      .sel_ready(sel_ready0), .sel_done(sel_done0), .sel_err(sel_err0), .active_ch(active_ch0),
      .bus_busy(bus_busy0), .scl_out(scl_out0), .sda_out(sda_out0));

   i2c_channel_mux #(.NUM_CH(NCH1), .SEL_W(3), .SYNC_STAGES(SS1), .IDLE_CYCLES(IC1)) dut1 (
      .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in), .sel(sel1), .sel_valid(sel_valid1),
      .sel_ready(sel_ready1), .sel_done(sel_done1), .sel_err(sel_err1), .active_ch(active_ch1),
      .bus_busy(bus_busy1), .scl_out(scl_out1), .sda_out(sda_out1));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: pin history per configuration plus the handshake/bus rules.
   int  nch [2] = '{NCH0, NCH1};
   int  ss  [2] = '{SS0, SS1};
   int  ic  [2] = '{IC0, IC1};
   bit  hs_scl [2][8];
   bit  hs_sda [2][8];
   int  idle_run [2], act [2], psel [2];
   bit  pend [2], busy [2], swt [2], done [2], err [2];
   bit [7:0] oscl [2], osda [2];

   task automatic model_reset(input int k);
      for (int i = 0; i < 8; i++) begin
         hs_scl[k][i] = 1'b1;
         hs_sda[k][i] = 1'b1;
      end
      idle_run[k] = 0; act[k] = 0; psel[k] = 0;
      pend[k] = 0; busy[k] = 0; swt[k] = 0; done[k] = 0; err[k] = 0;
      oscl[k] = 8'hFF; osda[k] = 8'hFF;
   endtask

   task automatic model_step(input int k, input bit v, input int s);
      bit sc, sd, pc, pd, st, sp, go, rdy;
      int ch;
      sc  = hs_scl[k][ss[k]-1];
      sd  = hs_sda[k][ss[k]-1];
      pc  = hs_scl[k][ss[k]];
      pd  = hs_sda[k][ss[k]];
      st  = pc && sc && pd && !sd;
      sp  = pc && sc && !pd && sd;
      rdy = !pend[k] && !swt[k];
      go  = !busy[k] && !swt[k] && pend[k] && (idle_run[k] == ic[k]) && !st;
      ch  = swt[k] ? psel[k] : act[k];
      oscl[k] = 8'hFF;
      osda[k] = 8'hFF;
      if (!go) begin
         oscl[k][ch] = sc;
         osda[k][ch] = sd;
      end
      done[k] = 0;
      err[k]  = 0;
      if (swt[k]) begin
         act[k] = psel[k]; pend[k] = 0; done[k] = 1; swt[k] = 0;
      end else if (busy[k]) begin
         if (sp) busy[k] = 0;
      end else if (st) begin
         busy[k] = 1;
      end else if (go) begin
         swt[k] = 1;
      end
      if (v && rdy) begin
         if (s >= nch[k]) begin
            err[k] = 1; done[k] = 1;
         end else if (s == act[k]) begin
            done[k] = 1;
         end else begin
            pend[k] = 1; psel[k] = s;
         end
      end
      if (sc && sd && !st) idle_run[k] = (idle_run[k] < ic[k]) ? idle_run[k] + 1 : idle_run[k];
      else idle_run[k] = 0;
      for (int i = 7; i > 0; i--) begin
         hs_scl[k][i] = hs_scl[k][i-1];
         hs_sda[k][i] = hs_sda[k][i-1];
      end
      hs_scl[k][0] = scl_in;
      hs_sda[k][0] = sda_in;
   endtask

   always @(posedge clk) begin
      if (rst) begin
         model_reset(0);
         model_reset(1);
      end else begin
         model_step(0, sel_valid0, int'(sel0));
         model_step(1, sel_valid1, int'(sel1));
      end
   end

   bit chk_en = 1'b0;

   always @(negedge clk) begin
      if (chk_en) begin
         check_eq("scl_out0",  32'(scl_out0),   32'(oscl[0]));
         check_eq("sda_out0",  32'(sda_out0),   32'(osda[0]));
         check_eq("active0",   32'(active_ch0), 32'(act[0]));
         check_eq("ready0",    32'(sel_ready0), 32'(!pend[0] && !swt[0]));
         check_eq("done0",     32'(sel_done0),  32'(done[0]));
         check_eq("err0",      32'(sel_err0),   32'(err[0]));
         check_eq("busy0",     32'(bus_busy0),  32'(busy[0]));
         check_eq("scl_out1",  32'({2'b11, scl_out1}), 32'(oscl[1]));
         check_eq("sda_out1",  32'({2'b11, sda_out1}), 32'(osda[1]));
         check_eq("active1",   32'(active_ch1), 32'(act[1]));
         check_eq("ready1",    32'(sel_ready1), 32'(!pend[1] && !swt[1]));
         check_eq("done1",     32'(sel_done1),  32'(done[1]));
         check_eq("err1",      32'(sel_err1),   32'(err[1]));
         check_eq("busy1",     32'(bus_busy1),  32'(busy[1]));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic req(input int k, input int s);
      if (k == 0) begin sel0 = 3'(s); sel_valid0 = 1'b1; end
      else        begin sel1 = 3'(s); sel_valid1 = 1'b1; end
      cyc(1);
      sel_valid0 = 1'b0;
      sel_valid1 = 1'b0;
   endtask

   initial begin
      cyc(3);
      chk_en = 1'b1;
      rst = 1'b0;

      // Reset state with idle lines
      cyc(SS0 + 1);
      check_eq("rst_scl0",   32'(scl_out0),   32'hFF);
      check_eq("rst_sda0",   32'(sda_out0),   32'hFF);
      check_eq("rst_act0",   32'(active_ch0), 32'd0);
      check_eq("rst_ready0", 32'(sel_ready0), 32'd1);
      check_eq("rst_sda1",   32'(sda_out1),   32'h3F);

      // Pass-through on channel 0 with explicit latency probe
      for (int i = 0; i < 4; i++) begin
         scl_in = ~scl_in;
         cyc(10);
      end
      scl_in = 1'b0;
      cyc(2);
      check_eq("lat2_scl0", 32'(scl_out0[0]), 32'd1);
      cyc(1);
      check_eq("lat3_scl0", 32'(scl_out0[0]), 32'd0);
      check_eq("lat3_rest", 32'(scl_out0[7:1]), 32'h7F);
      scl_in = 1'b1;
      cyc(10);

      // Switch to channel 5 while idle
      req(0, 5);
      check_eq("sw_ready_drop", 32'(sel_ready0), 32'd0);
      cyc(30);
      check_eq("sw_active5", 32'(active_ch0), 32'd5);
      scl_in = 1'b0; cyc(4);
      sda_in = 1'b0; cyc(4);
      check_eq("sw_sda_on5", 32'(sda_out0), 32'hDF);
      sda_in = 1'b1; cyc(4);
      scl_in = 1'b1; cyc(4);

      // Request deferred by an ongoing transaction
      sda_in = 1'b0; cyc(4);
      check_eq("tx_busy", 32'(bus_busy0), 32'd1);
      scl_in = 1'b0; cyc(3);
      req(0, 3);
      for (int b = 0; b < 6; b++) begin
         sda_in = 1'($urandom_range(0, 1)); cyc(2);
         scl_in = 1'b1; cyc(3);
         scl_in = 1'b0; cyc(2);
      end
      sda_in = 1'b0; cyc(2);
      scl_in = 1'b1; cyc(3);
      check_eq("tx_hold5", 32'(active_ch0), 32'd5);
      sda_in = 1'b1;
      cyc(IC0 + 3);
      check_eq("tx_still5", 32'(active_ch0), 32'd5);
      check_eq("tx_blank", 32'(scl_out0), 32'hFF);
      cyc(1);
      check_eq("tx_now3", 32'(active_ch0), 32'd3);
      check_eq("tx_done", 32'(sel_done0), 32'd1);

      // Out-of-range and no-op requests
      req(1, 7);
      check_eq("bad_err1",  32'(sel_err1),   32'd1);
      check_eq("bad_done1", 32'(sel_done1),  32'd1);
      check_eq("bad_act1",  32'(active_ch1), 32'd0);
      cyc(1);
      check_eq("bad_err_once", 32'(sel_err1), 32'd0);
      req(0, 3);
      check_eq("noop_done0", 32'(sel_done0),  32'd1);
      check_eq("noop_ready", 32'(sel_ready0), 32'd1);
      cyc(3);

      // Reset during a transaction with a pending request
      req(0, 5);
      cyc(IC0 + 4);
      check_eq("mid_act5", 32'(active_ch0), 32'd5);
      sda_in = 1'b0; cyc(4);
      scl_in = 1'b0; cyc(2);
      req(0, 2);
      check_eq("mid_pending", 32'(sel_ready0), 32'd0);
      rst = 1'b1;
      cyc(1);
      check_eq("mid_scl", 32'(scl_out0),   32'hFF);
      check_eq("mid_sda", 32'(sda_out0),   32'hFF);
      check_eq("mid_bsy", 32'(bus_busy0),  32'd0);
      check_eq("mid_act", 32'(active_ch0), 32'd0);
      check_eq("mid_rdy", 32'(sel_ready0), 32'd1);
      check_eq("mid_don", 32'(sel_done0),  32'd0);
      rst = 1'b0;
      scl_in = 1'b1; cyc(2);
      sda_in = 1'b1; cyc(5);

      // Randomised traffic: idle stretches and noise bursts with random requests
      for (int seg = 0; seg < 120; seg++) begin
         int mode, len;
         mode = $urandom_range(0, 2);
         len  = (mode == 0) ? $urandom_range(1, 40) : $urandom_range(1, 25);
         for (int c = 0; c < len; c++) begin
            if (mode == 0) begin
               scl_in = 1'b1; sda_in = 1'b1;
            end else begin
               scl_in = 1'($urandom_range(0, 1));
               sda_in = 1'($urandom_range(0, 1));
            end
            sel0 = 3'($urandom_range(0, 7));
            sel1 = 3'($urandom_range(0, 7));
            sel_valid0 = ($urandom_range(0, 7) == 0);
            sel_valid1 = ($urandom_range(0, 7) == 0);
            cyc(1);
         end
      end
      sel_valid0 = 1'b0;
      sel_valid1 = 1'b0;
      cyc(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
